// File: rtl/alu_reservation_station_pkg.sv
// rtl/alu_reservation_station_pkg.sv - shared ALU/RS types: control bits, data word, ROB tag, entry struct
package alu_reservation_station_pkg;

    localparam int WORD_W   = 64;
    localparam int RS_TAG_W = 4;

    typedef logic [WORD_W-1:0]   MemoryWord;
    typedef logic [RS_TAG_W-1:0] RobTag;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL,
        ALU_SRA, ALU_SLT, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE
    } aluop_t;

    typedef struct packed {
        aluop_t aluop;
        logic   usign;
    } control_bits;

    typedef struct packed {
        logic      rdy;
        RobTag     tag;
        MemoryWord value;
    } rs_operand_t;

    typedef struct packed {
        logic        valid;
        control_bits ctrl;
        RobTag       dest;
        rs_operand_t a;
        rs_operand_t b;
    } rs_entry_t;

    // Capture a matching CDB broadcast into a waiting operand.
    function automatic rs_operand_t rs_capture(rs_operand_t op, logic cdb_valid,
                                               RobTag cdb_tag, MemoryWord cdb_value);
        rs_operand_t r;
        r = op;
        if (!op.rdy && cdb_valid && (op.tag == cdb_tag)) begin
            r.rdy   = 1'b1;
            r.value = cdb_value;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_reservation_station_if.sv
// rtl/alu_reservation_station_if.sv - dispatch/CDB/issue bundle; master = upstream+ALU side, slave = RS
import alu_reservation_station_pkg::*;

interface alu_reservation_station_if #(parameter int TAG_W = 4);
    logic             flush;
    logic             disp_valid;
    logic             disp_ready;
    control_bits      disp_ctrl;
    logic [TAG_W-1:0] disp_tag;
    logic             disp_a_rdy, disp_b_rdy;
    MemoryWord        disp_a_val, disp_b_val;
    logic [TAG_W-1:0] disp_a_tag, disp_b_tag;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    MemoryWord        cdb_value;
    logic             issue_valid;
    logic             issue_ready;
    control_bits      issue_ctrl;
    MemoryWord        issue_a, issue_b;
    logic [TAG_W-1:0] issue_tag;

    modport master (
        output flush, disp_valid, disp_ctrl, disp_tag, disp_a_rdy, disp_b_rdy,
               disp_a_val, disp_b_val, disp_a_tag, disp_b_tag,
               cdb_valid, cdb_tag, cdb_value, issue_ready,
        input  disp_ready, issue_valid, issue_ctrl, issue_a, issue_b, issue_tag
    );

    modport slave (
        input  flush, disp_valid, disp_ctrl, disp_tag, disp_a_rdy, disp_b_rdy,
               disp_a_val, disp_b_val, disp_a_tag, disp_b_tag,
               cdb_valid, cdb_tag, cdb_value, issue_ready,
        output disp_ready, issue_valid, issue_ctrl, issue_a, issue_b, issue_tag
    );
endinterface

// File: rtl/alu_reservation_station_rs_select.sv
// rtl/alu_reservation_station_rs_select.sv - pick one eligible entry (lowest index, or oldest with RS_OLDEST_FIRST_EN)
// Ports: eligible_i (ready entries), older_i (age matrix, RS_OLDEST_FIRST_EN only), grant_o (one-hot), valid_o.
module alu_reservation_station_rs_select #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]       eligible_i,
`ifdef RS_OLDEST_FIRST_EN
    input  logic [DEPTH*DEPTH-1:0] older_i,
`endif
    output logic [DEPTH-1:0]       grant_o,
    output logic                   valid_o
);
`ifdef RS_OLDEST_FIRST_EN
    // older_i[i*DEPTH+j] set means entry i was dispatched before entry j.
    always_comb begin
        grant_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant_o[i] = eligible_i[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && eligible_i[j] && !older_i[i*DEPTH+j]) begin
                    grant_o[i] = 1'b0;
                end
            end
        end
    end
`else
    assign grant_o = eligible_i & (~eligible_i + DEPTH'(1));
`endif
    assign valid_o = |eligible_i;
endmodule

// File: rtl/alu_reservation_station.sv
// rtl/alu_reservation_station.sv - ALU reservation station: dispatch, CDB wakeup, one issue per cycle
// Ports: clk, rst_n (async active-low), rs (slave modport: flush, disp_*, cdb_*, issue_*).
// Optional: RS_OLDEST_FIRST_EN selects the oldest eligible entry instead of the lowest index.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    alu_reservation_station_if.slave rs
);
    rs_entry_t        ent_q [DEPTH];
    rs_entry_t        ent_d [DEPTH];
    logic [DEPTH-1:0] valid_vec, eligible, free_oh, arb_grant, grant;
    logic [DEPTH-1:0] grant_q;
    logic             hold_q;
    logic             arb_valid, issue_fire, disp_fire;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = ent_q[i].valid;
            eligible[i]  = ent_q[i].valid && ent_q[i].a.rdy && ent_q[i].b.rdy;
        end
    end

    // Lowest free slot, from registered state so an issuing slot is never reused in the same cycle.
    assign free_oh       = ~valid_vec & (valid_vec + DEPTH'(1));
    assign rs.disp_ready = ~&valid_vec;
    assign disp_fire     = rs.disp_valid && rs.disp_ready;

`ifdef RS_OLDEST_FIRST_EN
    logic [DEPTH*DEPTH-1:0] older_q, older_d;

    // A new entry is younger than every other slot.
    always_comb begin
        older_d = older_q;
        if (disp_fire) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (free_oh[k]) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        older_d[k*DEPTH+j] = 1'b0;
                        older_d[j*DEPTH+k] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) older_q <= '0;
        else        older_q <= older_d;
    end

    alu_reservation_station_rs_select #(.DEPTH(DEPTH)) u_select (
        .eligible_i (eligible),
        .older_i    (older_q),
        .grant_o    (arb_grant),
        .valid_o    (arb_valid)
    );
`else
    alu_reservation_station_rs_select #(.DEPTH(DEPTH)) u_select (
        .eligible_i (eligible),
        .grant_o    (arb_grant),
        .valid_o    (arb_valid)
    );
`endif

    // While stalled, keep presenting the same entry even if another one becomes preferable.
    assign grant          = hold_q ? grant_q : (arb_valid ? arb_grant : '0);
    assign rs.issue_valid = |grant;
    assign issue_fire     = rs.issue_valid && rs.issue_ready;

    always_comb begin
        rs.issue_ctrl = '0;
        rs.issue_a    = '0;
        rs.issue_b    = '0;
        rs.issue_tag  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                rs.issue_ctrl = ent_q[i].ctrl;
                rs.issue_a    = ent_q[i].a.value;
                rs.issue_b    = ent_q[i].b.value;
                rs.issue_tag  = ent_q[i].dest;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i]   = ent_q[i];
            ent_d[i].a = rs_capture(ent_q[i].a, rs.cdb_valid, rs.cdb_tag, rs.cdb_value);
            ent_d[i].b = rs_capture(ent_q[i].b, rs.cdb_valid, rs.cdb_tag, rs.cdb_value);
            if (issue_fire && grant[i]) begin
                ent_d[i].valid = 1'b0;
            end
            if (disp_fire && free_oh[i]) begin
                ent_d[i].valid = 1'b1;
                ent_d[i].ctrl  = rs.disp_ctrl;
                ent_d[i].dest  = rs.disp_tag;
                ent_d[i].a     = rs_capture('{rdy: rs.disp_a_rdy, tag: rs.disp_a_tag, value: rs.disp_a_val},
                                            rs.cdb_valid, rs.cdb_tag, rs.cdb_value);
                ent_d[i].b     = rs_capture('{rdy: rs.disp_b_rdy, tag: rs.disp_b_tag, value: rs.disp_b_val},
                                            rs.cdb_valid, rs.cdb_tag, rs.cdb_value);
            end
            if (rs.flush) begin
                ent_d[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            grant_q <= '0;
            hold_q  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            grant_q <= grant;
            hold_q  <= rs.issue_valid && !rs.issue_ready && !rs.flush;
        end
    end
endmodule

// File: tb/tb_alu_reservation_station.sv
// tb/tb_alu_reservation_station.sv - scoreboard bench for alu_reservation_station
module tb_alu_reservation_station;
    import alu_reservation_station_pkg::*;

    typedef struct {
        logic [3:0]  tag;
        logic [63:0] a;
        logic [63:0] b;
        control_bits ctrl;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    alu_reservation_station_if #(.TAG_W(4)) bus ();

    alu_reservation_station #(.DEPTH(4), .TAG_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rs    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input aluop_t op, input logic [3:0] tag,
                        input logic ar, input logic [63:0] av, input logic [3:0] at,
                        input logic br, input logic [63:0] bv, input logic [3:0] bt);
        bus.disp_valid = 1'b1;
        bus.disp_ctrl  = '{aluop: op, usign: 1'b0};
        bus.disp_tag   = tag;
        bus.disp_a_rdy = ar;
        bus.disp_a_val = av;
        bus.disp_a_tag = at;
        bus.disp_b_rdy = br;
        bus.disp_b_val = bv;
        bus.disp_b_tag = bt;
    endtask

    task automatic cdb(input logic v, input logic [3:0] tag, input logic [63:0] val);
        bus.cdb_valid = v;
        bus.cdb_tag   = tag;
        bus.cdb_value = val;
    endtask

    task automatic expect_issue(input logic [3:0] tag, input logic [63:0] a, input logic [63:0] b,
                                input aluop_t op);
        exp_t e;
        e.tag  = tag;
        e.a    = a;
        e.b    = b;
        e.ctrl = '{aluop: op, usign: 1'b0};
        sb.push_back(e);
    endtask

    // Scoreboard: every accepted issue is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.issue_valid && bus.issue_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_issue", 64'(sb.size()), 64'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("issue_tag", 64'(bus.issue_tag), 64'(e.tag));
                check("issue_a", bus.issue_a, e.a);
                check("issue_b", bus.issue_b, e.b);
                check("issue_ctrl", 64'(bus.issue_ctrl), 64'(e.ctrl));
            end
        end
    end

    initial begin
        rst_n           = 1'b0;
        bus.flush       = 1'b0;
        bus.disp_valid  = 1'b0;
        bus.issue_ready = 1'b0;
        disp(ALU_ADD, 4'd0, 1'b0, 64'd0, 4'd0, 1'b0, 64'd0, 4'd0);
        bus.disp_valid  = 1'b0;
        cdb(1'b0, 4'd0, 64'd0);
        repeat (3) tick();
        check("rst_disp_ready", 64'(bus.disp_ready), 64'd1);
        check("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
        check("rst_issue_a", bus.issue_a, 64'd0);
        check("rst_issue_b", bus.issue_b, 64'd0);
        check("rst_issue_tag", 64'(bus.issue_tag), 64'd0);
        rst_n = 1'b1;
        tick();

        // Both operands ready: issue the cycle after dispatch.
        bus.issue_ready = 1'b1;
        disp(ALU_ADD, 4'd5, 1'b1, 64'd5, 4'd0, 1'b1, 64'd7, 4'd0);
        expect_issue(4'd5, 64'd5, 64'd7, ALU_ADD);
        check("t1_no_same_cycle", 64'(bus.issue_valid), 64'd0);
        tick();
        bus.disp_valid = 1'b0;
        check("t1_issue_valid", 64'(bus.issue_valid), 64'd1);
        tick();
        check("t1_freed", 64'(bus.issue_valid), 64'd0);

        // b waits for tag 3, broadcast two cycles later.
        disp(ALU_SUB, 4'd8, 1'b1, 64'd10, 4'd0, 1'b0, 64'd0, 4'd3);
        expect_issue(4'd8, 64'd10, 64'd4, ALU_SUB);
        tick();
        bus.disp_valid = 1'b0;
        check("t2_waiting", 64'(bus.issue_valid), 64'd0);
        tick();
        cdb(1'b1, 4'd3, 64'd4);
        check("t2_no_bypass", 64'(bus.issue_valid), 64'd0);
        tick();
        cdb(1'b0, 4'd0, 64'd0);
        check("t2_woken", 64'(bus.issue_valid), 64'd1);
        tick();

        // Dispatch and matching CDB in the same cycle.
        disp(ALU_OR, 4'd9, 1'b1, 64'h11, 4'd0, 1'b0, 64'd0, 4'd6);
        cdb(1'b1, 4'd6, 64'h99);
        expect_issue(4'd9, 64'h11, 64'h99, ALU_OR);
        tick();
        bus.disp_valid = 1'b0;
        cdb(1'b0, 4'd0, 64'd0);
        check("t3_issue_valid", 64'(bus.issue_valid), 64'd1);
        tick();

        // Fill all four slots with pending operands.
        for (int i = 0; i < 4; i++) begin
            disp(ALU_AND, 4'(i + 1), 1'b0, 64'd0, 4'(10 + i), 1'b1, 64'(16 * i), 4'd0);
            tick();
            if (i == 2) check("t4_ready_at_3", 64'(bus.disp_ready), 64'd1);
        end
        bus.disp_valid = 1'b0;
        check("t4_full", 64'(bus.disp_ready), 64'd0);
        cdb(1'b1, 4'd12, 64'h30);
        expect_issue(4'd3, 64'h30, 64'd32, ALU_AND);
        tick();
        cdb(1'b0, 4'd0, 64'd0);
        check("t4_issue_valid", 64'(bus.issue_valid), 64'd1);
        check("t4_still_full", 64'(bus.disp_ready), 64'd0);
        tick();
        check("t4_slot_freed", 64'(bus.disp_ready), 64'd1);

        // Flush with three valid entries and a concurrent ready dispatch.
        bus.flush = 1'b1;
        disp(ALU_XOR, 4'd7, 1'b1, 64'd1, 4'd0, 1'b1, 64'd2, 4'd0);
        tick();
        bus.flush      = 1'b0;
        bus.disp_valid = 1'b0;
        check("t5_issue_valid", 64'(bus.issue_valid), 64'd0);
        check("t5_disp_ready", 64'(bus.disp_ready), 64'd1);
        cdb(1'b1, 4'd10, 64'd1);
        tick();
        cdb(1'b0, 4'd0, 64'd0);
        check("t5_no_stale_wake", 64'(bus.issue_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            disp(ALU_AND, 4'(i + 1), 1'b0, 64'd0, 4'd15, 1'b1, 64'd0, 4'd0);
            tick();
            if (i == 2) check("t5_empty_after_flush", 64'(bus.disp_ready), 64'd1);
        end
        bus.disp_valid = 1'b0;
        check("t5_refull", 64'(bus.disp_ready), 64'd0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;

        // Stalled issue holds its entry even when a lower slot wakes.
        bus.issue_ready = 1'b0;
        disp(ALU_ADD, 4'd3, 1'b0, 64'd0, 4'd5, 1'b1, 64'd1, 4'd0);
        tick();
        disp(ALU_SUB, 4'd4, 1'b1, 64'h44, 4'd0, 1'b1, 64'h45, 4'd0);
        tick();
        bus.disp_valid = 1'b0;
        check("t6_present", 64'(bus.issue_tag), 64'd4);
        cdb(1'b1, 4'd5, 64'h55);
        tick();
        cdb(1'b0, 4'd0, 64'd0);
        check("t6_hold1", 64'(bus.issue_tag), 64'd4);
        tick();
        check("t6_hold2", 64'(bus.issue_tag), 64'd4);
        check("t6_hold_b", bus.issue_b, 64'h45);
        expect_issue(4'd4, 64'h44, 64'h45, ALU_SUB);
        expect_issue(4'd3, 64'h55, 64'd1, ALU_ADD);
        bus.issue_ready = 1'b1;
        tick();
        tick();
        check("t6_drained", 64'(bus.issue_valid), 64'd0);

        // Age ordering: tag 1 in slot 1, tag 2 later in freed slot 0, both woken together.
        disp(ALU_ADD, 4'd14, 1'b0, 64'd0, 4'd11, 1'b1, 64'd0, 4'd0);
        tick();
        disp(ALU_BEQ, 4'd1, 1'b0, 64'd0, 4'd13, 1'b1, 64'h1, 4'd0);
        tick();
        bus.disp_valid = 1'b0;
        cdb(1'b1, 4'd11, 64'hE);
        expect_issue(4'd14, 64'hE, 64'd0, ALU_ADD);
        tick();
        cdb(1'b0, 4'd0, 64'd0);
        tick();
        disp(ALU_BNE, 4'd2, 1'b0, 64'd0, 4'd13, 1'b1, 64'h2, 4'd0);
        tick();
        bus.disp_valid = 1'b0;
        cdb(1'b1, 4'd13, 64'hAB);
`ifdef RS_OLDEST_FIRST_EN
        expect_issue(4'd1, 64'hAB, 64'h1, ALU_BEQ);
        expect_issue(4'd2, 64'hAB, 64'h2, ALU_BNE);
`else
        expect_issue(4'd2, 64'hAB, 64'h2, ALU_BNE);
        expect_issue(4'd1, 64'hAB, 64'h1, ALU_BEQ);
`endif
        tick();
        cdb(1'b0, 4'd0, 64'd0);

        for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
        check("sb_drain", 64'(sb.size()), 64'd0);

        // Reset mid-operation discards a pending entry.
        disp(ALU_ADD, 4'd6, 1'b0, 64'd0, 4'd9, 1'b1, 64'd0, 4'd0);
        tick();
        bus.disp_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_mid_disp_ready", 64'(bus.disp_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        cdb(1'b1, 4'd9, 64'd3);
        tick();
        cdb(1'b0, 4'd0, 64'd0);
        check("rst_mid_no_issue", 64'(bus.issue_valid), 64'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_reservation_station.md
# alu_reservation_station

Operand-holding issue queue that drives the ALU's input side: accepts dispatched integer/branch ops with source operands either as values or as pending ROB tags, snoops the common data bus (CDB) for outstanding tags, and issues one fully-ready op per cycle as `control_bits` plus two 64-bit operands. Sits between rename/dispatch and the ALU execute stage; the ALU's `result` and `take_branch` return via the CDB under the issued tag.

## Interface
Parameters:
- DEPTH, 4, number of entries (power of 2, ≥2)
- TAG_W, 4, ROB tag width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  mispredict/exception flush: discard all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  a free entry exists
- disp_ctrl  in  control_bits  aluop/usign for the op
- disp_tag  in  TAG_W  destination ROB tag
- disp_a_rdy, disp_b_rdy  in  1 each  operand already holds its value
- disp_a_val, disp_b_val  in  MemoryWord each  operand value (valid when rdy)
- disp_a_tag, disp_b_tag  in  TAG_W each  producer tag (valid when !rdy)
- cdb_valid  in  1  broadcast present
- cdb_tag  in  TAG_W  broadcast producer tag
- cdb_value  in  MemoryWord  broadcast result
- issue_valid  out  1  ready op presented
- issue_ready  in  1  execute stage accepts
- issue_ctrl  out  control_bits  to ALU `ctrl_bits`
- issue_a, issue_b  out  MemoryWord  to ALU `sourceA`/`sourceB`
- issue_tag  out  TAG_W  destination tag carried alongside

## Operation
- Entry: valid, ctrl, dest tag, per-operand {rdy, tag, value}, plus age info (see Configuration).
- Dispatch: handshake `disp_valid && disp_ready`; written into lowest-index invalid entry.
- Dispatch/CDB same cycle: operand with `!disp_x_rdy && cdb_valid && cdb_tag == disp_x_tag` is written ready with `cdb_value`.
- Wakeup: every valid entry with a non-ready operand whose tag matches a valid CDB broadcast captures `cdb_value`, sets rdy. Both operands may wake on one broadcast.
- Select: entry is eligible when valid and both operands rdy; one chosen per cycle. `issue_*` driven combinationally from the chosen entry.
- Issue: on `issue_valid && issue_ready` the chosen entry is invalidated. `issue_valid` low → `issue_*` data don't-care, hold stable while `issue_valid && !issue_ready` unless flush.
- `disp_ready = (occupancy < DEPTH)`, from registered state only; no same-cycle reuse of a slot being issued.
- Flush: all valid bits cleared at the edge; overrides dispatch, issue, and wakeup in that cycle (dispatched op dropped).
- No tag recycling check; upstream guarantees unique in-flight tags.

## Timing
- Reset (async assert): all entries invalid, occupancy 0; `disp_ready`=1, `issue_valid`=0, `issue_*` data 0.
- Dispatch with both operands ready at edge N → `issue_valid` earliest in cycle N+1.
- CDB wakeup at edge N → entry eligible in cycle N+1 (no same-cycle CDB-to-issue bypass).
- Throughput: 1 dispatch + 1 issue per cycle.
- Full: occupancy DEPTH → `disp_ready`=0; issue at edge N → `disp_ready`=1 in N+1.
- Empty with no eligible entry → `issue_valid`=0.
- Reset deasserted mid-operation: state restarts empty; no partial entries.

## Configuration
- `RS_OLDEST_FIRST_EN` defined: per-entry age tracking; select issues the eligible entry dispatched earliest. Ages maintained across issue and flush.
- Undefined: select issues lowest-index eligible entry; age state not built.

## Structure
- Shared package: existing `control_bits`, `MemoryWord`, aluop enum; add `RobTag` typedef and `rs_entry_t` struct.
- One sub-module: `rs_select` — takes eligible vector (and ages when enabled), returns one-hot grant and valid.

## Test plan
- Dispatch ADD, a=5, b=7 both ready, issue_ready=1 → next cycle issue_valid=1, issue_a=5, issue_b=7, issue_tag=disp_tag; entry freed.
- Dispatch SUB a ready=10, b pending tag 3; CDB tag 3 value 4 two cycles later → issue next cycle with issue_b=4.
- Dispatch with b pending tag 6 while cdb_valid, cdb_tag=6, cdb_value=0x99 same cycle → issued next cycle, issue_b=0x99.
- Fill 4 entries with pending operands → disp_ready=0; wake one via CDB, issue → disp_ready=1 following cycle.
- Flush with 3 valid entries plus concurrent dispatch → next cycle occupancy 0, issue_valid=0, disp_ready=1.
- With `RS_OLDEST_FIRST_EN`: dispatch tags 1 then 2 into slots 1 and 0 (slot freed), both woken same cycle → tag 1 issues first; without macro tag 2 (slot 0) first.
